// File: rtl/word_packer.sv
// Packs the byte stream from one selected decryptor into 32-bit words, first byte
// in the most significant lane. Partial words flush on idle timeout or source change.
module word_packer #(
  parameter int unsigned MST_DWIDTH   = 32,
  parameter int unsigned SYS_DWIDTH   = 8,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [1:0]            select,
  input  logic [SYS_DWIDTH-1:0] data0_i,
  input  logic                  valid0_i,
  input  logic [SYS_DWIDTH-1:0] data1_i,
  input  logic                  valid1_i,
  input  logic [SYS_DWIDTH-1:0] data2_i,
  input  logic                  valid2_i,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [3:0]            keep_o,
  output logic                  overflow_o
);

  localparam int unsigned LANES = 4;
  localparam int unsigned TW    = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

  logic [MST_DWIDTH-1:0] acc_q, acc_n, acc_w;
  logic [1:0]            cnt_q, cnt_n;
  logic [1:0]            sel_q, sel_n;
  logic [TW-1:0]         tmr_q, tmr_n;
  logic                  pend_q, pend_n;
  logic [3:0]            pkeep_q, pkeep_n;
  logic [MST_DWIDTH-1:0] data_n;
  logic [3:0]            keep_n;
  logic                  valid_n, ovf_n;

  logic [SYS_DWIDTH-1:0] byte_c;
  logic                  byte_in_c;
  logic                  slot_free_c;
  logic                  load_out_c;
  logic [MST_DWIDTH-1:0] out_word_c;
  logic [3:0]            out_keep_c;

  // Lane mask for a word holding c bytes, filled from lane 3 downward.
  function automatic logic [3:0] keep_of(input logic [1:0] c);
    return ~(4'b1111 >> c);
  endfunction

  // Source mux: only the channel named by select can deliver a byte.
  always_comb begin
    byte_c    = '0;
    byte_in_c = 1'b0;
    case (select)
      2'd0: begin byte_c = data0_i; byte_in_c = valid0_i; end
      2'd1: begin byte_c = data1_i; byte_in_c = valid1_i; end
      2'd2: begin byte_c = data2_i; byte_in_c = valid2_i; end
      default: begin byte_c = '0; byte_in_c = 1'b0; end
    endcase
  end

  // Accumulator with the current byte dropped into lane cnt_q.
  always_comb begin
    acc_w = acc_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (cnt_q == 2'(k)) acc_w[MST_DWIDTH-1-SYS_DWIDTH*k -: SYS_DWIDTH] = byte_c;
    end
  end

  // Next-state: commit triggers, pending commit and output slot handling.
  always_comb begin
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    sel_n       = sel_q;
    tmr_n       = tmr_q;
    pend_n      = pend_q;
    pkeep_n     = pkeep_q;
    ovf_n       = overflow_o;
    data_n      = data_o;
    keep_n      = keep_o;
    valid_n     = valid_o && !ready_i;
    load_out_c  = 1'b0;
    out_word_c  = acc_q;
    out_keep_c  = '0;
    slot_free_c = !valid_o || ready_i;

    if (pend_q) begin
      if (byte_in_c) ovf_n = 1'b1;
      if (slot_free_c) begin
        load_out_c = 1'b1;
        out_keep_c = pkeep_q;
        pend_n     = 1'b0;
        acc_n      = '0;
        cnt_n      = '0;
        tmr_n      = '0;
      end
    end else if (cnt_q != 2'd0 && select != sel_q) begin
      if (slot_free_c) begin
        load_out_c = 1'b1;
        out_keep_c = keep_of(cnt_q);
        acc_n      = '0;
        cnt_n      = '0;
        tmr_n      = '0;
        sel_n      = select;
        if (byte_in_c) begin
          acc_n[MST_DWIDTH-1 -: SYS_DWIDTH] = byte_c;
          cnt_n = 2'd1;
        end
      end else begin
        pend_n  = 1'b1;
        pkeep_n = keep_of(cnt_q);
        if (byte_in_c) ovf_n = 1'b1;
      end
    end else if (byte_in_c) begin
      tmr_n = '0;
      sel_n = select;
      if (cnt_q == 2'd3) begin
        if (slot_free_c) begin
          load_out_c = 1'b1;
          out_word_c = acc_w;
          out_keep_c = 4'b1111;
          acc_n      = '0;
          cnt_n      = '0;
        end else begin
          pend_n  = 1'b1;
          pkeep_n = 4'b1111;
          acc_n   = acc_w;
        end
      end else begin
        acc_n = acc_w;
        cnt_n = 2'(cnt_q + 2'd1);
      end
    end else if (cnt_q != 2'd0) begin
      if (tmr_q == TW'(IDLE_TIMEOUT - 1)) begin
        if (slot_free_c) begin
          load_out_c = 1'b1;
          out_keep_c = keep_of(cnt_q);
          acc_n      = '0;
          cnt_n      = '0;
          tmr_n      = '0;
        end else begin
          pend_n  = 1'b1;
          pkeep_n = keep_of(cnt_q);
        end
      end else begin
        tmr_n = TW'(tmr_q + TW'(1));
      end
    end else begin
      sel_n = select;
      tmr_n = '0;
    end

    if (load_out_c) begin
      data_n  = out_word_c;
      keep_n  = out_keep_c;
      valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      tmr_q      <= '0;
      pend_q     <= 1'b0;
      pkeep_q    <= '0;
      data_o     <= '0;
      keep_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      acc_q      <= acc_n;
      cnt_q      <= cnt_n;
      sel_q      <= sel_n;
      tmr_q      <= tmr_n;
      pend_q     <= pend_n;
      pkeep_q    <= pkeep_n;
      data_o     <= data_n;
      keep_o     <= keep_n;
      valid_o    <= valid_n;
      overflow_o <= ovf_n;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: directed scenarios plus randomized traffic,
// checked against a queue-based character model.
module tb_word_packer;

  localparam int unsigned TO = 8;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [1:0]  select  = 2'd0;
  logic [7:0]  data0_i = 8'd0, data1_i = 8'd0, data2_i = 8'd0;
  logic        valid0_i = 1'b0, valid1_i = 1'b0, valid2_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic [3:0]  keep_o;
  logic        overflow_o;

  always #5 clk_sys = ~clk_sys;

  word_packer #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .IDLE_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .select(select),
    .data0_i(data0_i), .valid0_i(valid0_i),
    .data1_i(data1_i), .valid1_i(valid1_i),
    .data2_i(data2_i), .valid2_i(valid2_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .keep_o(keep_o), .overflow_o(overflow_o)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  k;
  } wk_t;

  int errs   = 0;
  int checks = 0;
  wk_t exp_q[$];
  wk_t mon_e;

  // Model: characters of the word being built, plus an abstract output slot.
  byte unsigned m_chars[$];
  logic [1:0]   m_src;
  int           m_idle;
  bit           m_pend;
  wk_t          m_pw;
  bit           m_occ, m_ovf;
  bit           pre_occ, pre_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic wk_t pack_chars();
    wk_t r;
    r.w = '0;
    r.k = '0;
    for (int i = 0; i < m_chars.size(); i++) begin
      r.w = r.w | (32'(m_chars[i]) << (24 - 8 * i));
      r.k[3-i] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_chars.delete();
    exp_q.delete();
    m_src = 2'd0; m_idle = 0; m_pend = 0; m_pw = '0;
    m_occ = 0; m_ovf = 0; pre_occ = 0; pre_ovf = 0;
  endtask

  task automatic model_commit(input wk_t x, input bit free);
    if (free) begin
      exp_q.push_back(x);
      m_occ = 1;
      m_chars.delete();
      m_idle = 0;
    end else begin
      m_pend = 1;
      m_pw   = x;
    end
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_step(input logic [1:0] sel, input logic [2:0] vld,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic rdy);
    bit free, bin;
    byte unsigned b;
    pre_occ = m_occ;
    pre_ovf = m_ovf;
    free = !m_occ || rdy;
    if (m_occ && rdy) m_occ = 0;
    case (sel)
      2'd0: begin bin = vld[0]; b = d0; end
      2'd1: begin bin = vld[1]; b = d1; end
      2'd2: begin bin = vld[2]; b = d2; end
      default: begin bin = 0; b = 0; end
    endcase
    if (m_pend) begin
      if (bin) m_ovf = 1;
      if (free) begin
        m_pend = 0;
        model_commit(m_pw, 1);
      end
    end else if (m_chars.size() != 0 && sel != m_src) begin
      model_commit(pack_chars(), free);
      if (free) begin
        m_src = sel;
        if (bin) m_chars.push_back(b);
      end else if (bin) begin
        m_ovf = 1;
      end
    end else if (bin) begin
      m_chars.push_back(b);
      m_idle = 0;
      m_src  = sel;
      if (m_chars.size() == 4) model_commit(pack_chars(), free);
    end else if (m_chars.size() != 0) begin
      m_idle++;
      if (m_idle == TO) model_commit(pack_chars(), free);
    end else begin
      m_src = sel;
    end
  endtask

  task automatic cyc(input logic [1:0] sel, input logic [2:0] vld, input logic [7:0] d0,
                     input logic [7:0] d1, input logic [7:0] d2, input logic rdy);
    @(posedge clk_sys);
    #1;
    select = sel; valid0_i = vld[0]; valid1_i = vld[1]; valid2_i = vld[2];
    data0_i = d0; data1_i = d1; data2_i = d2; ready_i = rdy;
    model_step(sel, vld, d0, d1, d2, rdy);
  endtask

  task automatic put(input logic [1:0] sel, input int ch, input logic [7:0] d, input logic rdy);
    logic [7:0] r0, r1, r2;
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    case (ch)
      0: cyc(sel, 3'b001, d, r1, r2, rdy);
      1: cyc(sel, 3'b010, r0, d, r2, rdy);
      default: cyc(sel, 3'b100, r0, r1, d, rdy);
    endcase
  endtask

  task automatic idle(input logic [1:0] sel, input logic rdy);
    cyc(sel, 3'b000, 8'($urandom), 8'($urandom), 8'($urandom), rdy);
  endtask

  // Monitor: every cycle compare flags, and pop one word per handshake.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (rst_n) begin
        chk("valid_o", 32'(valid_o), 32'(pre_occ));
        chk("overflow_o", 32'(overflow_o), 32'(pre_ovf));
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL word: unexpected %h keep %b, none expected", data_o, keep_o);
          end else begin
            mon_e = exp_q.pop_front();
            chk("data_o", data_o, mon_e.w);
            chk("keep_o", 32'(keep_o), 32'(mon_e.k));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] rs;
    int pv, pr;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #2;
    chk("rst data_o", data_o, 32'h0);
    chk("rst keep_o", 32'(keep_o), 32'h0);
    chk("rst valid_o", 32'(valid_o), 32'h0);
    chk("rst overflow_o", 32'(overflow_o), 32'h0);
    rst_n = 1'b1;

    // Full word with ready high
    put(0, 0, 8'h41, 1); put(0, 0, 8'h42, 1); put(0, 0, 8'h43, 1); put(0, 0, 8'h44, 1);
    idle(0, 1);
    chk("full data", data_o, 32'h41424344);
    chk("full keep", 32'(keep_o), 32'hF);
    chk("full valid", 32'(valid_o), 32'h1);
    idle(0, 1);
    chk("full valid one cycle", 32'(valid_o), 32'h0);

    // Idle flush of two bytes
    put(1, 1, 8'h61, 1); put(1, 1, 8'h62, 1);
    repeat (TO) idle(1, 1);
    chk("flush not early", 32'(valid_o), 32'h0);
    idle(1, 1);
    chk("flush data", data_o, 32'h61620000);
    chk("flush keep", 32'(keep_o), 32'hC);
    chk("flush valid", 32'(valid_o), 32'h1);

    // Source change with a byte on the new channel
    put(0, 0, 8'h10, 1); put(0, 0, 8'h20, 1); put(0, 0, 8'h30, 1);
    put(2, 2, 8'h99, 1);
    idle(2, 1);
    chk("srcchg data", data_o, 32'h10203000);
    chk("srcchg keep", 32'(keep_o), 32'hE);
    put(2, 2, 8'hAA, 1); put(2, 2, 8'hBB, 1); put(2, 2, 8'hCC, 1);
    idle(2, 1);
    chk("srcchg next data", data_o, 32'h99AABBCC);
    chk("srcchg next keep", 32'(keep_o), 32'hF);

    // Backpressure: second word pends, ninth byte dropped
    for (int i = 1; i <= 9; i++) begin
      put(0, 0, 8'(i), 0);
      if (i == 5) chk("bp first data", data_o, 32'h01020304);
    end
    idle(0, 0);
    chk("bp overflow", 32'(overflow_o), 32'h1);
    chk("bp held data", data_o, 32'h01020304);
    idle(0, 1);
    idle(0, 1);
    chk("bp second data", data_o, 32'h05060708);
    chk("bp second valid", 32'(valid_o), 32'h1);
    idle(0, 1);
    chk("bp drained", 32'(valid_o), 32'h0);

    // Ignored inputs
    repeat (4) cyc(3, 3'b111, 8'h11, 8'h22, 8'h33, 1);
    repeat (4) cyc(0, 3'b110, 8'h11, 8'h22, 8'h33, 1);
    repeat (TO + 2) idle(0, 1);
    chk("ignored valid", 32'(valid_o), 32'h0);

    // Reset mid-word
    put(0, 0, 8'h12, 1); put(0, 0, 8'h34, 1);
    idle(0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst data_o", data_o, 32'h0);
    chk("midrst keep_o", 32'(keep_o), 32'h0);
    chk("midrst valid_o", 32'(valid_o), 32'h0);
    chk("midrst overflow_o", 32'(overflow_o), 32'h0);
    rst_n = 1'b1;
    model_reset();
    put(0, 0, 8'hDE, 1); put(0, 0, 8'hAD, 1); put(0, 0, 8'hBE, 1); put(0, 0, 8'hEF, 1);
    idle(0, 1);
    chk("post-rst data", data_o, 32'hDEADBEEF);
    chk("post-rst keep", 32'(keep_o), 32'hF);

    // Randomized traffic in phases of differing density and readiness
    rs = 2'd0;
    for (int ph = 0; ph < 20; ph++) begin
      pv = (ph % 3 == 0) ? 95 : ((ph % 3 == 1) ? 60 : 15);
      pr = (ph % 4 == 0) ? 100 : ((ph % 4 == 1) ? 25 : ((ph % 4 == 2) ? 50 : 10));
      for (int c = 0; c < 200; c++) begin
        logic [2:0] v;
        if ($urandom_range(19) == 0) rs = 2'($urandom_range(3));
        for (int j = 0; j < 3; j++) v[j] = ($urandom_range(99) < pv);
        cyc(rs, v, 8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(99) < pr));
      end
    end

    repeat (3 * TO) idle(3, 1);
    chk("scoreboard empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/word_packer.md
# word_packer

Single-clock packer that merges the byte streams from the Caesar, Scytale and ZigZag decryptors back into 32-bit words. It selects one decryptor output per `select` and assembles 4 consecutive characters, first received in the most significant lane. Completed words go to the downstream consumer over a valid/ready handshake. This is the return-path counterpart of the 32→8 input splitter.

## Interface
- `MST_DWIDTH`, 32, output word width; must equal 4×`SYS_DWIDTH`
- `SYS_DWIDTH`, 8, character width
- `IDLE_TIMEOUT`, 8, idle cycles (≥2) after which a partial word is flushed

- `clk_sys`  in  1  system clock, sole clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `select`  in  2  source: 00 Caesar, 01 Scytale, 10 ZigZag, 11 none
- `data0_i`/`valid0_i`  in  SYS_DWIDTH/1  Caesar decryptor output
- `data1_i`/`valid1_i`  in  SYS_DWIDTH/1  Scytale decryptor output
- `data2_i`/`valid2_i`  in  SYS_DWIDTH/1  ZigZag decryptor output
- `data_o`  out  MST_DWIDTH  packed word, first char in [31:24]
- `valid_o`  out  1  `data_o`/`keep_o` valid
- `ready_i`  in  1  downstream accepts word when `valid_o && ready_i`
- `keep_o`  out  4  lane-valid mask, bit 3 = [31:24]
- `overflow_o`  out  1  sticky: a character was dropped

## Operation
- Accepted byte: `valid<select>_i` high for the selected channel; unselected channels and `select`=11 are ignored; no input backpressure.
- Accumulator `acc`, lane count `cnt` (0..3), captured source `sel_q`, idle timer, `pend` flag.
- Byte k (k = `cnt`) is written to `acc[31-8k -: 8]`; `cnt` increments.
- Commit: `acc` with its lane mask moves to the output register; `acc`, `cnt`, timer clear. Triggers:
  - 4th byte accepted;
  - idle flush: `cnt`≠0, no byte for `IDLE_TIMEOUT` consecutive cycles; unfilled lanes are zero;
  - source change: `cnt`≠0 and `select`≠`sel_q`.
- Output slot is free when `!valid_o || ready_i`. If a commit triggers while the slot is not free, `pend`=1 and `acc` is frozen. Commit completes on the first edge the slot is free.
- While `pend`=1, every accepted byte is dropped and sets `overflow_o`.
- For a source-change commit, a byte on the new channel in the same cycle goes to lane 0 of the fresh word, provided `pend` does not result; otherwise it is dropped and sets overflow.
- `sel_q` loads `select` whenever `cnt`=0 and not `pend`.
- `data_o` and `keep_o` hold stable while `valid_o && !ready_i`.
- `overflow_o` clears only on reset.

## Timing
- Reset (async assert, sync-to-edge effect on release) sets all of these to 0: `data_o`, `keep_o`, `valid_o`, `overflow_o`, `acc`, `cnt`, timer, `pend`, `sel_q`.
- Reset mid-word discards the partial word; no flush.
- Latency: the 4th byte is sampled at edge N; `valid_o` is high from N with `keep_o`=1111.
- Back-to-back operation: a handshake at edge M with `pend`=1 reloads the output register at M. `valid_o` stays high and no bubble is inserted.
- Idle flush timing:
  - the last byte is at edge E;
  - the timer counts idle edges E+1 onward;
  - the flush commits at edge E+`IDLE_TIMEOUT`.
- If a byte arrives on the flush edge, the byte wins and the timer restarts; no flush occurs.
- The timer is frozen while `pend`=1.
- Sustained throughput: one byte/cycle with `ready_i` at least one cycle in four, with no loss.

## Test plan
- Full word, ready high: `select`=00; bytes 0x41,0x42,0x43,0x44 on ch0 in 4 consecutive cycles → `data_o`=0x41424344, `keep_o`=1111, `valid_o` high one cycle, overflow 0.
- Idle flush: `select`=01; bytes 0x61,0x62 on ch1, then 8 idle cycles → `data_o`=0x61620000, `keep_o`=1100 after the 8th idle edge.
- Source change: 0x10,0x20,0x30 on ch0, then `select`=10 with 0x99 on ch2 in the same cycle.
  - Required: `data_o`=0x10203000, `keep_o`=1110.
  - Next word starts 0x99; after 3 more bytes 0xAA,0xBB,0xCC → 0x99AABBCC.
- Backpressure/overflow: `ready_i`=0, stream 9 bytes 0x01..0x09 on ch0.
  - Required: first word 0x01020304 held.
  - Second word 0x05060708 is pending; 0x09 is dropped and `overflow_o`=1.
  - Raising `ready_i` yields 0x01020304 then 0x05060708 on consecutive cycles.
- Ignored inputs: `select`=11, or traffic only on unselected channels → `valid_o` stays 0, `cnt` stays 0.
- Reset mid-word: 2 bytes accepted, then `rst_n` pulsed low between edges → all outputs 0 immediately. A following 4-byte word 0xDEADBEEF packs correctly with `keep_o`=1111.
